i2c_data_in: RTL

Receive-side data path of the I2C master: after the master has sent a read address, this block samples SDA on each SCL-high strobe, assembles MSB-first bytes into an 8-entry byte array, and drives ACK/NACK on every ninth SCL clock: ACK on all bytes but the last, NACK on the last. It pairs with the transmit data path. It is paced by the same bit-timing strobes (drive phase and sample phase) from the master's SCL generator. It reports completion to the master control FSM.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_data_in_if.sv | 36 +++
 rtl/i2c_data_in_sipo.sv | 37 +++
 rtl/i2c_data_in.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master receive and transmit data paths.
//   MAX_BYTES   depth of the byte array; larger transfer lengths are clamped
//   ACK_LVL     AckDrive level that pulls SDA low (acknowledge)
//   NACK_LVL    AckDrive level that releases SDA (not-acknowledge)
//   rx_state_t  receive FSM states
//   byte_arr_t  byte array shared by both data paths
package i2c_pkg;

   localparam int         MAX_BYTES = 8;
   localparam int         IDX_W     = $clog2(MAX_BYTES);
   localparam logic [3:0] MAX_LEN   = 4'(MAX_BYTES);

   localparam logic ACK_LVL  = 1'b1;
   localparam logic NACK_LVL = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      ACK_SET,
      ACK_HOLD,
      ACK_REL
   } rx_state_t;

   typedef logic [7:0] byte_arr_t [0:MAX_BYTES-1];

   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

endpackage

// File: rtl/i2c_data_in_if.sv
// Bundle between the master control / SCL generator (master side) and the
// receive data path (slave side).
//   start, length, abort      transfer control from the master FSM
//   drive_strobe              SCL-low phase pulse, SDA may change
//   sample_strobe             SCL-high phase pulse, SDA stable
//   sda_in                    synchronized SDA level
//   ack_drive                 1 pulls SDA low
//   data, byte_valid          received byte array and per-byte write pulse
//   byte_index, busy, done    progress and completion status
interface i2c_data_in_if;
   import i2c_pkg::*;

   logic             start;
   logic [3:0]       length;
   logic             abort;
   logic             drive_strobe;
   logic             sample_strobe;
   logic             sda_in;
   logic             ack_drive;
   byte_arr_t        data;
   logic             byte_valid;
   logic [IDX_W-1:0] byte_index;
   logic             busy;
   logic             done;

   modport master (
      output start, length, abort, drive_strobe, sample_strobe, sda_in,
      input  ack_drive, data, byte_valid, byte_index, busy, done
   );

   modport slave (
      input  start, length, abort, drive_strobe, sample_strobe, sda_in,
      output ack_drive, data, byte_valid, byte_index, busy, done
   );

endinterface

// File: rtl/i2c_data_in_sipo.sv
// 8-bit serial-in parallel-out shift register, MSB first. Counterpart of the
// transmit-side parallel-in serial-out register.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        restart the byte (clears bits and count)
//   i_shift        shift i_bit into the LSB
//   i_bit          serial input
//   o_next         byte value including the bit being shifted this cycle
//   o_full         high in the cycle the 8th bit is shifted in
module i2c_data_in_sipo (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clear,
   input  logic       i_shift,
   input  logic       i_bit,
   output logic [7:0] o_next,
   output logic       o_full
);

   // Only 7 bits are stored: the 8th completes the byte and is consumed
   // straight from o_next by the writer in the same cycle.
   logic [6:0] r_shift;
   logic [2:0] r_count;

   assign o_next = {r_shift, i_bit};
   assign o_full = i_shift && (r_count == 3'd7);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (i_shift) begin
         r_shift <= o_next[6:0];
         r_count <= r_count + 3'd1;
      end
   end

endmodule

// File: rtl/i2c_data_in.sv
// Receive data path of the I2C master: assembles MSB-first bytes from SDA on
// SCL-high strobes, stores them in a byte array and drives ACK on every byte
// except the last, which gets NACK.
//   i_clk, i_rst   clock, synchronous active-high reset
//   io_bus         slave side of i2c_data_in_if (control, strobes, SDA in,
//                  AckDrive, Data array, ByteValid, ByteIndex, Busy, Done)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for Start; zero-length Start just pulses Done
// SHIFT    | sampling 8 data bits on SampleStrobe
// ACK_SET  | waiting for DriveStrobe to present ACK/NACK on SDA
// ACK_HOLD | ACK/NACK on the bus, waiting for the ninth SCL-high strobe
// ACK_REL  | waiting for DriveStrobe to release SDA, then next byte or end
module i2c_data_in
   import i2c_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst,
   i2c_data_in_if.slave   io_bus
);

   rx_state_t        r_state, w_state_nxt;
   logic [3:0]       r_len;
   logic [IDX_W-1:0] r_idx;
   logic             r_ack, r_valid, r_done;
   byte_arr_t        r_data;

   logic             w_sample, w_drive, w_last, w_full;
   logic [7:0]       w_byte;
   logic [3:0]       w_len_in;
   logic             w_load, w_sipo_clr, w_wr, w_ack_set, w_ack_rel;
   logic             w_done_nxt, w_idx_inc, w_idx_clr;

   // SampleStrobe wins when both strobes arrive together.
   assign w_sample = io_bus.sample_strobe;
   assign w_drive  = io_bus.drive_strobe && !io_bus.sample_strobe;
   assign w_last   = ({1'b0, r_idx} == (r_len - 4'd1));
   assign w_len_in = clamp_len(io_bus.length);

   i2c_data_in_sipo u_sipo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (w_sipo_clr),
      .i_shift ((r_state == SHIFT) && w_sample),
      .i_bit   (io_bus.sda_in),
      .o_next  (w_byte),
      .o_full  (w_full)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_sipo_clr  = 1'b0;
      w_wr        = 1'b0;
      w_ack_set   = 1'b0;
      w_ack_rel   = 1'b0;
      w_done_nxt  = 1'b0;
      w_idx_inc   = 1'b0;
      w_idx_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (io_bus.start) begin
               w_load = 1'b1;
               if (w_len_in == 4'd0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_sipo_clr  = 1'b1;
                  w_idx_clr   = 1'b1;
                  w_state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (w_full) begin
               w_wr        = 1'b1;
               w_state_nxt = ACK_SET;
            end
         end
         ACK_SET: begin
            if (w_drive) begin
               w_ack_set   = 1'b1;
               w_state_nxt = ACK_HOLD;
            end
         end
         ACK_HOLD: begin
            if (w_sample) w_state_nxt = ACK_REL;
         end
         ACK_REL: begin
            if (w_drive) begin
               w_ack_rel = 1'b1;
               if (w_last) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_idx_inc   = 1'b1;
                  w_sipo_clr  = 1'b1;
                  w_state_nxt = SHIFT;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Abort drops everything in flight; bytes already stored are kept.
      if (io_bus.abort) begin
         w_state_nxt = IDLE;
         w_load      = 1'b0;
         w_wr        = 1'b0;
         w_ack_set   = 1'b0;
         w_done_nxt  = 1'b0;
         w_idx_inc   = 1'b0;
         w_idx_clr   = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_idx   <= '0;
         r_ack   <= NACK_LVL;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < MAX_BYTES; i++) r_data[i] <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_wr;
         r_done  <= w_done_nxt;
         if (w_load) r_len <= w_len_in;
         if (w_idx_clr)      r_idx <= '0;
         else if (w_idx_inc) r_idx <= r_idx + 1'b1;
         if (w_wr) r_data[r_idx] <= w_byte;
         if (io_bus.abort)   r_ack <= NACK_LVL;
         else if (w_ack_set) r_ack <= w_last ? NACK_LVL : ACK_LVL;
         else if (w_ack_rel) r_ack <= NACK_LVL;
      end
   end

   assign io_bus.ack_drive  = r_ack;
   assign io_bus.data       = r_data;
   assign io_bus.byte_valid = r_valid;
   assign io_bus.byte_index = r_idx;
   assign io_bus.busy       = (r_state != IDLE);
   assign io_bus.done       = r_done;

endmodule
